// File: rtl/alu_cmd_ctrl_if.sv
// Command and response handshakes between a requester and the alu_cmd_ctrl front-end.
// The master modport belongs to the requester/consumer; the slave modport belongs to the controller.
interface alu_cmd_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_use_acc;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_x;
  logic [3:0] rsp_y;
  logic [3:0] rsp_op;
  logic       rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_x, rsp_y, rsp_op, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_x, rsp_y, rsp_op, rsp_zero
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Registered command front-end for the 4-bit alu: accept -> drive alu -> capture masked result (2 edges).
// One command in flight; cmd_ready is low in EXEC/RESP and the response holds until rsp_ready.
module alu_cmd_ctrl (
  input  logic               clk,
  input  logic               rst,
  alu_cmd_ctrl_if.slave      bus,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [3:0]         alu_opcode,
  input  logic [3:0]         alu_x,
  input  logic [3:0]         alu_y,
  output logic [3:0]         acc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       accept;
  logic       capture;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [3:0] rsp_x;
  logic [3:0] rsp_y;
  logic [3:0] rsp_op;
  logic       rsp_zero;
  logic [3:0] mask_x;
  logic [3:0] mask_y;

  // The alu only drives the bits an opcode defines; everything else is stale and must be cleared.
  always_comb begin
    mask_x = alu_x;
    mask_y = 4'b0000;
    if (alu_opcode <= 4'b1001) begin
      mask_x = {3'b000, alu_x[0]};
    end else if (alu_opcode == 4'b1010) begin
      mask_y = {3'b000, alu_y[0]};
    end else if (alu_opcode == 4'b1100 || alu_opcode == 4'b1101 ||
                 alu_opcode == 4'b1110) begin
      mask_y = alu_y;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (bus.cmd_valid && !rst) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_opcode <= 4'd0;
      rsp_x      <= 4'd0;
      rsp_y      <= 4'd0;
      rsp_op     <= 4'd0;
      rsp_zero   <= 1'b1;
      acc        <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_opcode <= bus.cmd_op;
        alu_a      <= bus.cmd_use_acc ? acc : bus.cmd_a;
        alu_b      <= bus.cmd_b;
      end
      if (capture) begin
        rsp_x    <= mask_x;
        rsp_y    <= mask_y;
        rsp_op   <= alu_opcode;
        rsp_zero <= ({mask_y, mask_x} == 8'd0);
        acc      <= mask_x;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_x     = rsp_x;
  assign bus.rsp_y     = rsp_y;
  assign bus.rsp_op    = rsp_op;
  assign bus.rsp_zero  = rsp_zero;

  // A stalled response must not move until the consumer takes it.
  property p_rsp_hold;
    @(posedge clk) disable iff (rst)
      (rsp_valid && !bus.rsp_ready) |=>
        (rsp_valid && $stable(rsp_x) && $stable(rsp_y) && $stable(rsp_op) && $stable(rsp_zero));
  endproperty
  a_rsp_hold: assert property (p_rsp_hold);

  property p_one_in_flight;
    @(posedge clk) disable iff (rst) !(cmd_ready && rsp_valid);
  endproperty
  a_one_in_flight: assert property (p_one_in_flight);

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Sequential command front-end for the 4-bit combinational `alu`. Accepts operation commands over a valid/ready handshake and drives the ALU's `a`, `b` and `opcode` inputs from registers. It samples the ALU's `x`/`y` results one cycle later, masks the result bits that are not defined for the opcode, and returns them over a second valid/ready handshake. A 4-bit accumulator holds the last result so commands can be chained.

## Interface
- No parameters; all data widths are fixed at 4 bits to match `alu`.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `cmd_valid` in 1 — command present.
- `cmd_ready` out 1 — controller can accept a command.
- `cmd_op` in 4 — ALU opcode.
- `cmd_a` in 4 — operand A.
- `cmd_b` in 4 — operand B.
- `cmd_use_acc` in 1 — when 1, operand A is the accumulator and `cmd_a` is ignored.
- `alu_a` out 4, `alu_b` out 4, `alu_opcode` out 4 — registered drive to the `alu` instance.
- `alu_x` in 4, `alu_y` in 4 — `alu` outputs.
- `rsp_valid` out 1 — response present.
- `rsp_ready` in 1 — consumer accepts the response.
- `rsp_x` out 4, `rsp_y` out 4 — masked result (low nibble, high nibble).
- `rsp_op` out 4 — opcode of this response.
- `rsp_zero` out 1 — 1 when {`rsp_y`, `rsp_x`} == 0.
- `acc` out 4 — accumulator value.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: `cmd_ready` = 1.
  - On `cmd_valid` && `cmd_ready`, register the command: `alu_opcode` ← `cmd_op`; `alu_a` ← (`cmd_use_acc` ? `acc` : `cmd_a`); `alu_b` ← `cmd_b`.
  - Go to EXEC.
- EXEC: `cmd_ready` = 0. At the end of the cycle:
  - capture the masked `alu_x`/`alu_y` into `rsp_x`/`rsp_y`;
  - `rsp_op` ← `alu_opcode`;
  - compute `rsp_zero`;
  - `acc` ← masked x;
  - go to RESP.
- RESP: `rsp_valid` = 1. All `rsp_*` outputs hold stable until `rsp_valid` && `rsp_ready`, then go to IDLE.
- Masking rules (the ALU leaves unassigned bits holding stale values, so the controller must mask):
  - opcodes 0000–1001: `rsp_x` = {3'b000, `alu_x`[0]}, `rsp_y` = 0;
  - 1010 (add): `rsp_x` = `alu_x`, `rsp_y` = {3'b000, `alu_y`[0]} (carry);
  - 1011 (sub) and 1111 (not): `rsp_x` = `alu_x`, `rsp_y` = 0;
  - 1100, 1101, 1110: `rsp_x` = `alu_x`, `rsp_y` = `alu_y`.
- Arithmetic is modulo the captured widths. Subtraction wraps mod 16, with no borrow flag.
- `alu_*` registers keep their values after EXEC until the next accept.

## Timing
- Reset values:
  - `cmd_ready` = 0 during the reset cycle and 1 in the first cycle after reset is released;
  - `rsp_valid` = 0;
  - `rsp_x`, `rsp_y`, `rsp_op`, `acc`, `alu_a`, `alu_b`, `alu_opcode` = 0;
  - `rsp_zero` = 1.
- Latency: a command accepted at edge E0 drives the ALU in the cycle after E0. The result is captured at E1, and `rsp_valid` is high from E1. This is 2 edges from accept to response.
- Throughput with `rsp_ready` tied high: one command per 3 cycles (IDLE → EXEC → RESP).
- `cmd_ready` is low in EXEC and RESP. `cmd_valid` in those states is ignored, and the command is not consumed.
- The response handshake completes on the edge where `rsp_valid` && `rsp_ready`. `cmd_ready` rises in the following cycle; IDLE is never skipped.
- `rsp_ready` high before `rsp_valid` is legal and has no effect.
- `cmd_use_acc` in the same accept cycle as an `acc` update cannot occur, because accepts happen only in IDLE.
- Reset in any state, including mid-EXEC or RESP with a pending response:
  - the next state is IDLE;
  - `rsp_valid` drops at that edge and the pending response is discarded;
  - `acc` is cleared.

## Test plan
- Add with carry: op 1010, a=9, b=8 → `rsp_x`=0001, `rsp_y`=0001, `rsp_zero`=0. `rsp_valid` rises 2 edges after accept.
- Multiply: op 1100, a=15, b=15 → `rsp_x`=0001, `rsp_y`=1110 (225).
- Masking after stale state:
  - op 1100, a=15, b=15, then op 0000, a=0 → `rsp_x`=0000, `rsp_y`=0000, `rsp_zero`=1;
  - stale `alu_x`[3:1] and `alu_y` must not leak into the response.
- Accumulator chain:
  - op 1011, a=3, b=5 → `rsp_x`=1110, `acc`=1110;
  - then op 1111 with `cmd_use_acc`=1, `cmd_a`=0 → `alu_a`=1110, `rsp_x`=0001.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP with `cmd_valid`=1 → `rsp_*` stable, `cmd_ready`=0, no second command consumed. Raising `rsp_ready` completes the handshake, and `cmd_ready`=1 in the next cycle.
- Reset mid-response: assert `rst` for one cycle while in RESP → `rsp_valid`=0, `acc`=0, `alu_opcode`=0. The next command runs normally.
